// File: rtl/reg_wb_arbiter.sv
// Write-back port arbiter: two one-entry capture buffers granted oldest-first onto a registered
// register-file write port, plus a per-register pending-write scoreboard for hazard detection.
module reg_wb_arbiter #(
   parameter int unsigned WORD_WIDTH     = 32,
   parameter int unsigned REG_FILE_DEPTH = 4,
   parameter int unsigned REG_FILE_SIZE  = 16,
   parameter int unsigned CNT_WIDTH      = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req0_valid,
   input  logic [REG_FILE_DEPTH-1:0] req0_dest,
   input  logic [WORD_WIDTH-1:0]     req0_data,
   output logic                      req0_ready,
   input  logic                      req1_valid,
   input  logic [REG_FILE_DEPTH-1:0] req1_dest,
   input  logic [WORD_WIDTH-1:0]     req1_data,
   output logic                      req1_ready,
   input  logic                      issue_en,
   input  logic [REG_FILE_DEPTH-1:0] issue_dest,
   output logic                      issue_stall,
   input  logic [REG_FILE_DEPTH-1:0] src1,
   input  logic [REG_FILE_DEPTH-1:0] src2,
   output logic                      hazard1,
   output logic                      hazard2,
   output logic                      WB_en,
   output logic [REG_FILE_DEPTH-1:0] WB_dest,
   output logic [WORD_WIDTH-1:0]     WB_result,
   output logic                      sb_error
);

   localparam int NumRegs = int'(REG_FILE_SIZE);
   localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

   logic                      buf0_valid_q, buf1_valid_q;
   logic [REG_FILE_DEPTH-1:0] buf0_dest_q, buf1_dest_q;
   logic [WORD_WIDTH-1:0]     buf0_data_q, buf1_data_q;
   // Set when buf1 holds the older write; only meaningful while both buffers are valid.
   logic                      older1_q, older1_d;
   logic                      grant0, grant1, capture0, capture1;

   logic [CNT_WIDTH-1:0] count_q [REG_FILE_SIZE];
   logic [CNT_WIDTH-1:0] count_d [REG_FILE_SIZE];
   logic [CNT_WIDTH-1:0] issue_cnt, src1_cnt, src2_cnt;
   logic                 err_set;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (buf0_valid_q && buf1_valid_q) begin
         grant0 = !older1_q;
         grant1 = older1_q;
      end else begin
         grant0 = buf0_valid_q;
         grant1 = buf1_valid_q;
      end
   end

   assign req0_ready = !buf0_valid_q | grant0;
   assign req1_ready = !buf1_valid_q | grant1;
   assign capture0   = req0_valid & req0_ready;
   assign capture1   = req1_valid & req1_ready;

   always_comb begin
      older1_d = older1_q;
      if (capture0 && capture1) begin
         older1_d = 1'b0;
      end else if (capture0 && buf1_valid_q && !grant1) begin
         older1_d = 1'b1;
      end else if (capture1 && buf0_valid_q && !grant0) begin
         older1_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf0_valid_q <= 1'b0;
         buf1_valid_q <= 1'b0;
         buf0_dest_q  <= '0;
         buf1_dest_q  <= '0;
         buf0_data_q  <= '0;
         buf1_data_q  <= '0;
         older1_q     <= 1'b0;
         WB_en        <= 1'b0;
         WB_dest      <= '0;
         WB_result    <= '0;
      end else begin
         buf0_valid_q <= capture0 | (buf0_valid_q & !grant0);
         buf1_valid_q <= capture1 | (buf1_valid_q & !grant1);
         if (capture0) begin
            buf0_dest_q <= req0_dest;
            buf0_data_q <= req0_data;
         end
         if (capture1) begin
            buf1_dest_q <= req1_dest;
            buf1_data_q <= req1_data;
         end
         older1_q <= older1_d;
         WB_en    <= grant0 | grant1;
         if (grant0) begin
            WB_dest   <= buf0_dest_q;
            WB_result <= buf0_data_q;
         end else if (grant1) begin
            WB_dest   <= buf1_dest_q;
            WB_result <= buf1_data_q;
         end
      end
   end

   // Out-of-range indices match no counter, so they read as zero and are never counted.
   always_comb begin
      issue_cnt = '0;
      src1_cnt  = '0;
      src2_cnt  = '0;
      for (int i = 0; i < NumRegs; i++) begin
         if (issue_dest == REG_FILE_DEPTH'(i)) issue_cnt = count_q[i];
         if (src1 == REG_FILE_DEPTH'(i))       src1_cnt  = count_q[i];
         if (src2 == REG_FILE_DEPTH'(i))       src2_cnt  = count_q[i];
      end
   end

   always_comb begin
      issue_stall = 1'b0;
      for (int i = 0; i < NumRegs; i++) begin
         if (issue_en && issue_dest == REG_FILE_DEPTH'(i) && count_q[i] == CntMax) begin
            issue_stall = 1'b1;
         end
      end
   end

   assign hazard1 = (src1_cnt != '0);
   assign hazard2 = (src2_cnt != '0);

   always_comb begin
      err_set = 1'b0;
      for (int i = 0; i < NumRegs; i++) begin
         count_d[i] = count_q[i];
         if (issue_en && !issue_stall && issue_dest == REG_FILE_DEPTH'(i)) begin
            if (!(WB_en && WB_dest == REG_FILE_DEPTH'(i))) begin
               count_d[i] = count_q[i] + CNT_WIDTH'(1);
            end
         end else if (WB_en && WB_dest == REG_FILE_DEPTH'(i)) begin
            if (count_q[i] == '0) begin
               err_set = 1'b1;
            end else begin
               count_d[i] = count_q[i] - CNT_WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NumRegs; i++) count_q[i] <= '0;
         sb_error <= 1'b0;
      end else begin
         for (int i = 0; i < NumRegs; i++) count_q[i] <= count_d[i];
         sb_error <= sb_error | err_set;
      end
   end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: fixed per-cycle stimulus with hand-computed expectations.
module tb_reg_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [3:0]  req0_dest, req1_dest, issue_dest, src1, src2, WB_dest;
   logic [31:0] req0_data, req1_data, WB_result;
   logic        issue_en, issue_stall, hazard1, hazard2, WB_en, sb_error;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   logic [31:0] rf [16];

   always #5 clk = ~clk;

   reg_wb_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_dest  (req0_dest),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_dest  (req1_dest),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .issue_en   (issue_en),
      .issue_dest (issue_dest),
      .issue_stall(issue_stall),
      .src1       (src1),
      .src2       (src2),
      .hazard1    (hazard1),
      .hazard2    (hazard2),
      .WB_en      (WB_en),
      .WB_dest    (WB_dest),
      .WB_result  (WB_result),
      .sb_error   (sb_error)
   );

   // Register file as the write port would update it.
   always @(posedge clk) if (WB_en) rf[WB_dest] <= WB_result;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to 2 time units after the next rising edge, then drop all requests.
   task automatic tick();
      @(posedge clk);
      #2;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      issue_en   = 1'b0;
   endtask

   task automatic put0(input logic [3:0] d, input logic [31:0] v);
      req0_valid = 1'b1;
      req0_dest  = d;
      req0_data  = v;
   endtask

   task automatic put1(input logic [3:0] d, input logic [31:0] v);
      req1_valid = 1'b1;
      req1_dest  = d;
      req1_data  = v;
   endtask

   task automatic issue(input logic [3:0] d);
      issue_en   = 1'b1;
      issue_dest = d;
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req0_dest = '0; req0_data = '0;
      req1_valid = 1'b0; req1_dest = '0; req1_data = '0;
      issue_en = 1'b0; issue_dest = '0; src1 = '0; src2 = '0;
      for (int i = 0; i < 16; i++) rf[i] = '0;
      tick(); tick();
      #1;
      chk("reset_wb_en", {31'b0, WB_en}, 32'd0);
      chk("reset_ready0", {31'b0, req0_ready}, 32'd1);

      // Reset while buf0 holds a write and WB_en is high.
      rst = 1'b0;
      put0(4'd6, 32'h55); issue(4'd6);
      tick();
      put0(4'd6, 32'h66); issue(4'd6);
      tick();
      src1 = 4'd6;
      #1;
      chk("pre_rst_wb_en", {31'b0, WB_en}, 32'd1);
      chk("pre_rst_hazard", {31'b0, hazard1}, 32'd1);
      rst = 1'b1;
      tick();
      #1;
      chk("rst_wb_en", {31'b0, WB_en}, 32'd0);
      chk("rst_wb_dest", {28'b0, WB_dest}, 32'd0);
      chk("rst_wb_result", WB_result, 32'd0);
      chk("rst_hazard1", {31'b0, hazard1}, 32'd0);
      chk("rst_sb_error", {31'b0, sb_error}, 32'd0);
      chk("rst_ready0", {31'b0, req0_ready}, 32'd1);
      rst = 1'b0;
      tick();
      #1;
      chk("rst_drop_buf", {31'b0, WB_en}, 32'd0);

      // Single uncontended write: visible in cycle 2 only.
      put0(4'd3, 32'hDEADBEEF); issue(4'd3); src1 = 4'd3; src2 = 4'd3;
      tick();
      #1;
      chk("single_c1_en", {31'b0, WB_en}, 32'd0);
      chk("single_c1_haz", {31'b0, hazard1}, 32'd1);
      tick();
      #1;
      chk("single_c2_en", {31'b0, WB_en}, 32'd1);
      chk("single_c2_dest", {28'b0, WB_dest}, 32'd3);
      chk("single_c2_data", WB_result, 32'hDEADBEEF);
      chk("single_c2_haz2", {31'b0, hazard2}, 32'd1);
      tick();
      #1;
      chk("single_c3_en", {31'b0, WB_en}, 32'd0);
      chk("single_c3_haz", {31'b0, hazard1}, 32'd0);

      // Simultaneous requests: buf0 wins, buf1 waits one cycle.
      put0(4'd1, 32'h11); put1(4'd2, 32'h22); issue(4'd1);
      tick();
      issue(4'd2);
      #1;
      chk("simul_c1_ready1", {31'b0, req1_ready}, 32'd0);
      chk("simul_c1_ready0", {31'b0, req0_ready}, 32'd1);
      tick();
      #1;
      chk("simul_c2_dest", {28'b0, WB_dest}, 32'd1);
      chk("simul_c2_data", WB_result, 32'h11);
      chk("simul_c2_ready1", {31'b0, req1_ready}, 32'd1);
      tick();
      #1;
      chk("simul_c3_en", {31'b0, WB_en}, 32'd1);
      chk("simul_c3_dest", {28'b0, WB_dest}, 32'd2);
      chk("simul_c3_data", WB_result, 32'h22);
      tick();
      #1;
      chk("simul_c4_en", {31'b0, WB_en}, 32'd0);

      // Ordering: req1 (dest 5) waits behind buf0; later req0 to dest 5 must follow it.
      put0(4'd8, 32'h80); put1(4'd5, 32'hA); issue(4'd8);
      tick();
      put0(4'd5, 32'hB); issue(4'd5);
      tick();
      issue(4'd5);
      #1;
      chk("order_c2_dest", {28'b0, WB_dest}, 32'd8);
      tick();
      #1;
      chk("order_c3_dest", {28'b0, WB_dest}, 32'd5);
      chk("order_c3_data", WB_result, 32'hA);
      tick();
      #1;
      chk("order_c4_data", WB_result, 32'hB);
      tick();
      src1 = 4'd5;
      #1;
      chk("order_rf5", rf[5], 32'hB);
      chk("order_haz5", {31'b0, hazard1}, 32'd0);

      // Saturation on register 7, then drain with three commits.
      src1 = 4'd7;
      for (int k = 0; k < 3; k++) begin
         issue(4'd7);
         #1;
         chk("sat_no_stall", {31'b0, issue_stall}, 32'd0);
         tick();
      end
      issue(4'd7);
      #1;
      chk("sat_haz", {31'b0, hazard1}, 32'd1);
      chk("sat_stall", {31'b0, issue_stall}, 32'd1);
      tick();
      put0(4'd7, 32'h71);
      tick();
      put0(4'd7, 32'h72);
      tick();
      put0(4'd7, 32'h73);
      #1;
      chk("sat_c1_wb", {31'b0, WB_en}, 32'd1);
      tick();
      #1;
      chk("sat_c2_haz", {31'b0, hazard1}, 32'd1);
      tick();
      #1;
      chk("sat_c3_wb_data", WB_result, 32'h73);
      chk("sat_c3_haz", {31'b0, hazard1}, 32'd1);
      tick();
      #1;
      chk("sat_drained", {31'b0, hazard1}, 32'd0);

      // Issue to 4 in the same cycle that 4 commits: count stays at 1.
      src1 = 4'd4;
      put0(4'd4, 32'h44); issue(4'd4);
      tick();
      tick();
      issue(4'd4);
      #1;
      chk("same_wb_dest", {28'b0, WB_dest}, 32'd4);
      tick();
      #1;
      chk("same_haz", {31'b0, hazard1}, 32'd1);
      chk("same_sb_err", {31'b0, sb_error}, 32'd0);
      put0(4'd4, 32'h45);
      tick(); tick(); tick();
      #1;
      chk("same_drained", {31'b0, hazard1}, 32'd0);

      // Commit to 9 with no pending issue: sticky error.
      src2 = 4'd9;
      put0(4'd9, 32'h99);
      tick(); tick(); tick();
      #1;
      chk("spur_err", {31'b0, sb_error}, 32'd1);
      chk("spur_haz2", {31'b0, hazard2}, 32'd0);
      tick(); tick();
      #1;
      chk("spur_sticky", {31'b0, sb_error}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("spur_rst_clear", {31'b0, sb_error}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
